// File: rtl/aucohl_fifo_th_if.sv
// FIFO bus bundle: request/data/threshold inputs and status outputs.
`timescale 1ns/1ps
interface aucohl_fifo_th_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    localparam int unsigned CW = AW + 1;

    logic          wr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic [DW-1:0] rdata;
    logic          flush;
    logic [CW-1:0] afull_th;
    logic [CW-1:0] aempty_th;
    logic          err_clr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] level;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr, wdata, rd, flush, afull_th, aempty_th, err_clr,
        input  rdata, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr, wdata, rd, flush, afull_th, aempty_th, err_clr,
        output rdata, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/aucohl_fifo_th.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/empty thresholds and flush.
// Define AUCOHL_FIFO_TH_ERR_EN to build the sticky overflow/underflow flags.
`timescale 1ns/1ps
module aucohl_fifo_th #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    aucohl_fifo_th_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          w_acc_c, r_acc_c;

    // Flush blocks both sides; full/empty gate their own side only.
    always_comb begin
        w_acc_c = bus.wr & ~full_q  & ~bus.flush;
        r_acc_c = bus.rd & ~empty_q & ~bus.flush;
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        if (bus.flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            level_d = '0;
        end else begin
            if (w_acc_c) w_ptr_d = w_ptr_q + AW'(1);
            if (r_acc_c) r_ptr_d = r_ptr_q + AW'(1);
            level_d = level_q + CW'(w_acc_c) - CW'(r_acc_c);
        end
        // Status comes from the count, so a full ring never aliases with empty.
        full_d  = (level_d == CW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_comb begin
        mem_d = mem_q;
        if (w_acc_c) mem_d[w_ptr_q] = bus.wdata;
    end

    // Storage carries no reset; contents are only meaningful behind the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

`ifdef AUCOHL_FIFO_TH_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr stays set.
    always_comb begin
        overflow_d  = (overflow_q  & ~bus.err_clr) | (bus.wr & full_q  & ~bus.flush);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.rd & empty_q & ~bus.flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

    assign bus.rdata        = mem_q[r_ptr_q];
    assign bus.level        = level_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = (level_q >= bus.afull_th);
    assign bus.almost_empty = (level_q <= bus.aempty_th);
endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Directed + random bench for aucohl_fifo_th against a queue-based reference model.
`timescale 1ns/1ps
module tb_aucohl_fifo_th;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef AUCOHL_FIFO_TH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aucohl_fifo_th_if #(.DW(DW), .AW(AW)) bus_if ();
    aucohl_fifo_th #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned sz;
        sz = mq.size();
        check({tag, ".level"}, 32'(bus_if.level), sz);
        check({tag, ".full"},  32'(bus_if.full),  32'(sz == DEPTH));
        check({tag, ".empty"}, 32'(bus_if.empty), 32'(sz == 0));
        check({tag, ".afull"}, 32'(bus_if.almost_full),  32'(sz >= 32'(bus_if.afull_th)));
        check({tag, ".aempty"},32'(bus_if.almost_empty), 32'(sz <= 32'(bus_if.aempty_th)));
        check({tag, ".ovf"},   32'(bus_if.overflow),  32'(ERR_EN & m_ovf));
        check({tag, ".unf"},   32'(bus_if.underflow), 32'(ERR_EN & m_unf));
        if (sz != 0) check({tag, ".rdata"}, 32'(bus_if.rdata), 32'(mq[0]));
    endtask

    // Reference behaviour expressed on the queue, using state before the edge.
    task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit ec);
        int unsigned sz;
        sz = mq.size();
        if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (f) begin
            mq.delete();
        end else begin
            if (w && sz == DEPTH) m_ovf = 1'b1;
            if (r && sz == 0)     m_unf = 1'b1;
            if (r && sz != 0)     void'(mq.pop_front());
            if (w && sz != DEPTH) mq.push_back(d);
        end
    endtask

    task automatic cyc(input string tag, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit f, input bit ec);
        bus_if.wr = w; bus_if.wdata = d; bus_if.rd = r;
        bus_if.flush = f; bus_if.err_clr = ec;
        model_step(w, d, r, f, ec);
        @(posedge clk);
        #1;
        check_all(tag);
        bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.flush = 1'b0; bus_if.err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.wr = 1'b0; bus_if.wdata = '0; bus_if.rd = 1'b0; bus_if.flush = 1'b0;
        bus_if.err_clr = 1'b0; bus_if.afull_th = CW'(12); bus_if.aempty_th = CW'(2);
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        bus_if.afull_th = '0;
        #1;
        check("reset.afull_th0", 32'(bus_if.almost_full), 32'd1);
        bus_if.afull_th = CW'(12);
        rst_n = 1'b1;

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        check("fill.full16", 32'(bus_if.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("drain.head", 32'(bus_if.rdata), 32'(i));
            cyc("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Overflow: write to full, then clear, then drain without seeing 0xAA.
        for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cyc("ovf", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Empty with wr & rd: write wins, read raises underflow.
        cyc("wr_rd_empty", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        cyc("unf_clr", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Level 8 streaming with pointer wrap.
        for (int i = 0; i < 8; i++) cyc("pre8", 1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc("stream", 1'b1, DW'(8'h88 + i), 1'b1, 1'b0, 1'b0);

        // Flush at level 10 with concurrent wr & rd.
        cyc("to10a", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc("to10b", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        cyc("flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        cyc("post_flush_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        cyc("post_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Threshold stepping 0..16..0, then reset mid-climb.
        bus_if.afull_th = CW'(14); bus_if.aempty_th = CW'(2);
        #1;
        check_all("th_change");
        for (int i = 0; i < 16; i++) cyc("step_up", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc("step_dn", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)  cyc("climb", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc("climb_ovf_probe", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check_all("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_first_wr", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cyc("rst_second_wr", 1'b1, 8'h78, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush, error clear and threshold changes.
        for (int i = 0; i < 400; i++) begin
            bit w, r, f, ec;
            w  = ($urandom_range(99) < 55);
            r  = ($urandom_range(99) < 45);
            f  = ($urandom_range(99) < 3);
            ec = ($urandom_range(99) < 5);
            if ($urandom_range(99) < 5) begin
                bus_if.afull_th  = CW'($urandom_range(31));
                bus_if.aempty_th = CW'($urandom_range(31));
                #1;
                check_all("rand_th");
            end
            cyc("rand", w, DW'($urandom), r, f, ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/aucohl_fifo_th.md
# aucohl_fifo_th

Synchronous single-clock FIFO with parametrised data width and depth, a full-range occupancy count, and programmable almost-full/almost-empty thresholds. It also provides a synchronous flush and optional sticky overflow/underflow error flags. It sits between peripheral shift engines (UART, SPI, I2C) and the bus-interface registers. Threshold flags drive interrupt/DMA requests; error flags feed the status register.

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 4, address width; DEPTH = 2**AW entries; count/threshold width CW = AW+1

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr  input  1  write request
- wdata  input  DW  write data
- rd  input  1  read request (pops head entry)
- rdata  output  DW  head entry, show-ahead (combinational from storage at read pointer)
- flush  input  1  synchronous clear of contents
- afull_th  input  CW  almost-full threshold
- aempty_th  input  CW  almost-empty threshold
- err_clr  input  1  clear sticky error flags
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- almost_full  output  1  level >= afull_th
- almost_empty  output  1  level <= aempty_th
- level  output  CW  occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Accepted write: w_acc = wr & ~full & ~flush. It stores wdata at w_ptr and increments w_ptr (mod DEPTH).
- Accepted read: r_acc = rd & ~empty & ~flush. It increments r_ptr (mod DEPTH).
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- level_next = level + w_acc - r_acc. level is CW bits wide, so DEPTH is representable (no aliasing of full with 0).
- full and empty are registered and derived from level_next; they are never computed from pointer equality.
- Full with wr & rd: the read is accepted, the write is dropped, and overflow is raised.
- Empty with wr & rd: the write is accepted, the read is dropped, and underflow is raised.
- Otherwise wr & rd with both accepted: level is unchanged and both pointers advance.
- Flush has highest priority: pointers := 0, level := 0, empty := 1, full := 0. Storage contents are not cleared. Concurrent wr/rd are ignored and raise no error flag.
- almost_full and almost_empty are combinational compares on registered level against live threshold inputs.
  - afull_th = 0 gives almost_full constantly 1.
  - aempty_th >= DEPTH gives almost_empty constantly 1.
- Error flags:
  - Set: overflow on wr & full & ~flush; underflow on rd & empty & ~flush.
  - Cleared by err_clr. Set wins over clear in the same cycle.
  - Flush does not clear them.
- rdata is undefined while empty; the bench must not check it then.

## Timing
- Reset values: level=0, empty=1, full=0, overflow=0, underflow=0, pointers=0. almost_empty=1 (level 0 <= any threshold). almost_full = (afull_th==0). rdata is undefined.
- Write-to-read latency is 1 cycle. Data written at edge N is on rdata, with empty=0, after edge N.
- On a read accepted at edge N, the next entry is on rdata after edge N.
- level, full, empty and the error flags update on the edge following the causing request. Threshold flags follow level in the same cycle.
- When a threshold input changes, the almost_full/almost_empty flags reflect it in the same cycle (no register).
- Asserting rst_n mid-operation immediately forces all reset values. The first accepted write after release lands at entry 0.

## Configuration
- Macro: AUCOHL_FIFO_TH_ERR_EN.
- Defined: the overflow/underflow sticky registers and err_clr logic are built as described.
- Undefined: the overflow and underflow ports remain, tied to 1'b0. err_clr is ignored. Drop/accept rules for wr/rd are identical.

## Test plan
- DW=8, AW=4: write 0x00..0x0F -> full=1, level=16, almost_full=1 (afull_th=12). Read 16 -> data 0x00..0x0F in order, then empty=1, level=0.
- Fill to 16, then wr=1 with wdata=0xAA -> overflow=1, level stays 16, 0xAA never read. Pulse err_clr -> overflow=0.
- Empty FIFO, wr=1 and rd=1 same cycle with wdata=0x5A -> level=1, underflow=1, rdata=0x5A next cycle.
- Level 8, continuous wr & rd for 40 cycles with an incrementing pattern -> level stays 8, pointers wrap, data order is preserved with no loss.
- Level 10, flush together with wr & rd -> level=0, empty=1, no error flag. The next write is read back correctly.
- aempty_th=2, afull_th=14: step level 0..16..0 -> almost_empty=1 exactly at levels 0-2, almost_full=1 exactly at levels 14-16. Assert rst_n mid-sequence -> all reset values hold immediately.
